ctrl_trace_encoder: RTL and testbench
=====================================

CTRL_TRACE_ENCODER -- requirements
Module: ctrl_trace_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  synchronous active-low reset.
REQ-003 SHALL have ports: sample_valid  in  1  control word present this cycle.
REQ-004 SHALL have ports: J, JC, INA, RM, WM, SIN, SOUT, WR, NEQ  in  1 each  decoded control word to re-encode.
REQ-005 SHALL have ports: flush  in  1  pulse, close open run.
REQ-006 SHALL have ports: clr_ovf  in  1  clear overflow and drop_cnt.
REQ-007 SHALL have ports: out_ready  in  1  consumer accepts byte.
REQ-008 SHALL have ports: out_valid  out  1  trace byte available.
REQ-009 SHALL have ports: out_data  out  8  {illegal[7], opcode[6:4], runlen_m1[3:0]}.
REQ-010 SHALL have ports: overflow  out  1  sticky, byte dropped.
REQ-011 SHALL have ports: drop_cnt  out  8  saturating dropped-byte count.
REQ-012 SHALL have ports: busy  out  1  open run or FIFO non-empty.

Function
REQ-013 SHALL map the control word to an opcode combinationally: SOUT only->000; INA+SIN->001; WM->010; RM+WR->011; J->100; JC->101; WR only->110; JC+NEQ->111; all other asserted bits zero in each case.
REQ-014 SHALL treat any other pattern, including all-zero, as symbol {illegal=1, opcode=000}.
REQ-015 SHALL keep one open run (run_active, symbol, cnt 0..15); on sample_valid with no open run, open one with cnt=0.
REQ-016 SHALL, on sample_valid with a matching symbol and cnt<15, increment cnt and emit nothing.
REQ-017 SHALL, on sample_valid with a differing symbol, or a matching symbol at cnt=15, emit the open run and open a new run with cnt=0 in the same cycle.
REQ-018 SHALL, on flush with sample_valid low, emit the open run (if any) and clear run_active; flush with no open run SHALL be a no-op.
REQ-019 SHALL, on flush with sample_valid high, process the sample normally and hold the flush pending until the first cycle with sample_valid low.
REQ-020 SHALL write each emitted byte into a 4-entry FIFO; the byte SHALL appear on out_valid/out_data the cycle after the emitting edge.
REQ-021 SHALL present out_valid = FIFO non-empty with out_data = head, and SHALL pop on out_valid and out_ready; out_data SHALL stay stable while out_valid is high and out_ready is low.
REQ-022 SHALL, when full with no pop, drop the emitted byte, set overflow, and increment drop_cnt, saturating at 255.
REQ-023 SHALL, when full with a simultaneous pop, accept the push with no drop.
REQ-024 SHALL, on clr_ovf, clear overflow and drop_cnt; a drop in the same cycle SHALL take precedence (overflow=1, drop_cnt=1).
REQ-025 SHALL drive busy = run_active or FIFO non-empty.

Reset
REQ-026 SHALL, with rst_n low at a clock edge, clear run_active, cnt, pending flush, FIFO pointers, overflow, and drop_cnt; out_valid=0, out_data=0, busy=0.
REQ-027 SHALL, on reset mid-run or mid-handshake, discard the open run and all FIFO contents without emitting them.

Configuration
REQ-028 SHALL, with CTRL_TRACE_RLE_EN defined, run-length merge as in REQ-015..017.
REQ-029 SHALL, without CTRL_TRACE_RLE_EN, emit one byte per sample_valid with runlen_m1=0, keep no open run, and treat flush as a no-op.

Structure
REQ-030 SHALL place opcode constants OP_R..OP_JCN, out_data field positions, FIFO depth 4, and max run 15 in the shared package ctrl_trace_pkg.
REQ-031 SHALL implement the FIFO as sub-module ctrl_trace_fifo, 8-bit wide, depth 4, with a full/empty push/pop interface.

Verification
REQ-032 SHALL cover: 3 consecutive samples of SOUT only, then flush, with out_ready=1 -> one byte 0x02.
REQ-033 SHALL cover: 17 consecutive samples of J -> bytes 0x4F then, after flush, 0x40.
REQ-034 SHALL cover: samples WM, then RM+WR, then J+WM -> bytes 0x20, 0x30, then 0x80 after flush.
REQ-035 SHALL cover: out_ready=0 and 6 alternating samples of JC / JC+NEQ, then flush -> 4 bytes held (0x50, 0x70, 0x50, 0x70), overflow=1, drop_cnt=2.
REQ-036 SHALL cover: rst_n low during an open run with 2 bytes queued -> out_valid=0 and busy=0 the next cycle, and no stale byte afterwards.
REQ-037 SHALL cover: build without CTRL_TRACE_RLE_EN, 2 samples of INA+SIN -> two bytes 0x10, 0x10.

Source files
------------

// File: rtl/ctrl_trace_pkg.sv
// Shared constants and helpers for the control-word trace encoder.
// Symbols are {illegal, opcode}; trace bytes are {illegal, opcode, runlen_m1}.
package ctrl_trace_pkg;

   typedef enum logic [2:0] {
      OP_R   = 3'd0,
      OP_INA = 3'd1,
      OP_WM  = 3'd2,
      OP_RM  = 3'd3,
      OP_J   = 3'd4,
      OP_JC  = 3'd5,
      OP_WR  = 3'd6,
      OP_JCN = 3'd7
   } opcode_t;

   typedef struct packed {
      logic    illegal;
      opcode_t opcode;
   } sym_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } run_state_t;

   localparam int DATA_W      = 8;
   localparam int FIFO_DEPTH  = 4;
   localparam int FIFO_AW     = 2;
   localparam int BIT_ILLEGAL = 7;
   localparam int OP_MSB      = 6;
   localparam int OP_LSB      = 4;
   localparam int RUN_MSB     = 3;
   localparam int RUN_LSB     = 0;
   localparam logic [3:0] MAX_RUN = 4'd15;

   // word = {J, JC, INA, RM, WM, SIN, SOUT, WR, NEQ}
   function automatic sym_t encode_sym(input logic [8:0] word);
      sym_t s;
      s.illegal = 1'b0;
      s.opcode  = OP_R;
      case (word)
         9'b000000100: s.opcode = OP_R;
         9'b001001000: s.opcode = OP_INA;
         9'b000010000: s.opcode = OP_WM;
         9'b000100010: s.opcode = OP_RM;
         9'b100000000: s.opcode = OP_J;
         9'b010000000: s.opcode = OP_JC;
         9'b000000010: s.opcode = OP_WR;
         9'b010000001: s.opcode = OP_JCN;
         default:      s.illegal = 1'b1;
      endcase
      return s;
   endfunction

   function automatic logic [DATA_W-1:0] pack_byte(input sym_t s, input logic [3:0] runlen_m1);
      logic [DATA_W-1:0] b;
      b                  = '0;
      b[BIT_ILLEGAL]     = s.illegal;
      b[OP_MSB:OP_LSB]   = s.opcode;
      b[RUN_MSB:RUN_LSB] = runlen_m1;
      return b;
   endfunction

endpackage

// File: rtl/ctrl_trace_fifo.sv
// 8-bit x 4 trace byte FIFO; a push while full is accepted only when a pop
// happens on the same edge. Head reads as zero while empty.
module ctrl_trace_fifo
   import ctrl_trace_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0]  mem [FIFO_DEPTH];
   logic [FIFO_AW:0]   wr_ptr;
   logic [FIFO_AW:0]   rd_ptr;
   logic               rd_en;
   logic               wr_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);

   assign pop_data = empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/ctrl_trace_encoder.sv
// Re-encodes decoded control words into trace bytes, run-length merged when
// CTRL_TRACE_RLE_EN is defined, otherwise one byte per sample.
//  state   | meaning
//  ST_IDLE | no open run
//  ST_RUN  | run_sym repeated run_cnt+1 times, not yet emitted
module ctrl_trace_encoder
   import ctrl_trace_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_valid,
   input  logic              J,
   input  logic              JC,
   input  logic              INA,
   input  logic              RM,
   input  logic              WM,
   input  logic              SIN,
   input  logic              SOUT,
   input  logic              WR,
   input  logic              NEQ,
   input  logic              flush,
   input  logic              clr_ovf,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              overflow,
   output logic [7:0]        drop_cnt,
   output logic              busy
);

   run_state_t        state, state_nxt;
   sym_t              run_sym, run_sym_nxt;
   logic [3:0]        run_cnt, run_cnt_nxt;
   logic              flush_pend, flush_pend_nxt;
   sym_t              cur_sym;
   logic              emit;
   logic [DATA_W-1:0] emit_byte;
   logic              full, empty, pop, drop;

   assign cur_sym = encode_sym({J, JC, INA, RM, WM, SIN, SOUT, WR, NEQ});

`ifdef CTRL_TRACE_RLE_EN
   always_comb begin
      state_nxt      = state;
      run_sym_nxt    = run_sym;
      run_cnt_nxt    = run_cnt;
      flush_pend_nxt = flush_pend;
      emit           = 1'b0;
      emit_byte      = pack_byte(run_sym, run_cnt);
      if (sample_valid) begin
         flush_pend_nxt = flush_pend || flush;
         if (state == ST_RUN && run_sym == cur_sym && run_cnt != MAX_RUN) begin
            run_cnt_nxt = run_cnt + 4'd1;
         end else begin
            emit        = (state == ST_RUN);
            state_nxt   = ST_RUN;
            run_sym_nxt = cur_sym;
            run_cnt_nxt = '0;
         end
      end else if (flush || flush_pend) begin
         // a flush seen during a sample burst closes the run on the first gap
         emit           = (state == ST_RUN);
         state_nxt      = ST_IDLE;
         run_cnt_nxt    = '0;
         flush_pend_nxt = 1'b0;
      end
   end
`else
   logic unused_flush;
   assign unused_flush = flush;

   always_comb begin
      state_nxt      = ST_IDLE;
      run_sym_nxt    = run_sym;
      run_cnt_nxt    = run_cnt;
      flush_pend_nxt = flush_pend;
      emit           = sample_valid;
      emit_byte      = pack_byte(cur_sym, 4'd0);
   end
`endif

   assign pop  = out_valid && out_ready;
   assign drop = emit && full && !pop;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         run_sym    <= '0;
         run_cnt    <= '0;
         flush_pend <= 1'b0;
         overflow   <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         run_sym    <= run_sym_nxt;
         run_cnt    <= run_cnt_nxt;
         flush_pend <= flush_pend_nxt;
         if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf)                drop_cnt <= 8'd1;
            else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
         end
      end
   end

   ctrl_trace_fifo u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (emit),
      .push_data (emit_byte),
      .pop       (pop),
      .pop_data  (out_data),
      .full      (full),
      .empty     (empty)
   );

   assign out_valid = !empty;
   assign busy      = (state == ST_RUN) || !empty;

endmodule

// File: tb/tb_ctrl_trace_encoder.sv
// Self-checking bench for ctrl_trace_encoder: queue-based reference model plus
// literal expectations; follows CTRL_TRACE_RLE_EN like the design.
module tb_ctrl_trace_encoder;

`ifdef CTRL_TRACE_RLE_EN
   localparam bit RLE = 1'b1;
`else
   localparam bit RLE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n, sample_valid, flush, clr_ovf, out_ready;
   logic       J, JC, INA, RM, WM, SIN, SOUT, WR, NEQ;
   logic [8:0] word;
   logic       out_valid, overflow, busy;
   logic [7:0] out_data, drop_cnt;

   assign {J, JC, INA, RM, WM, SIN, SOUT, WR, NEQ} = word;

   always #5 clk = ~clk;

   ctrl_trace_encoder dut (
      .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
      .J(J), .JC(JC), .INA(INA), .RM(RM), .WM(WM), .SIN(SIN), .SOUT(SOUT),
      .WR(WR), .NEQ(NEQ), .flush(flush), .clr_ovf(clr_ovf), .out_ready(out_ready),
      .out_valid(out_valid), .out_data(out_data), .overflow(overflow),
      .drop_cnt(drop_cnt), .busy(busy)
   );

   int tests = 0;
   int fails = 0;

   // legal words in opcode order; symbol value 8 means {illegal=1, opcode=0}
   logic [8:0] legal [8] = '{9'h004, 9'h048, 9'h010, 9'h022, 9'h100, 9'h080, 9'h002, 9'h081};

   int m_act, m_sym, m_cnt, m_pend, m_ovf, m_dcnt;
   int q[$];
   int log_q[$];

   function automatic int sym_of(input logic [8:0] w);
      for (int i = 0; i < 8; i++) if (w == legal[i]) return i;
      return 8;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_act = 0; m_sym = 0; m_cnt = 0; m_pend = 0; m_ovf = 0; m_dcnt = 0;
      q.delete();
   endtask

   task automatic model_update(input bit sv, input logic [8:0] w, input bit fl,
                               input bit clr, input bit pop);
      int e;
      e = -1;
      if (RLE) begin
         if (sv) begin
            if (m_act != 0 && sym_of(w) == m_sym && m_cnt < 15) m_cnt++;
            else begin
               if (m_act != 0) e = m_sym * 16 + m_cnt;
               m_act = 1; m_sym = sym_of(w); m_cnt = 0;
            end
            if (fl) m_pend = 1;
         end else if (fl || m_pend != 0) begin
            if (m_act != 0) e = m_sym * 16 + m_cnt;
            m_act = 0; m_pend = 0;
         end
      end else if (sv) begin
         e = sym_of(w) * 16;
      end
      if (pop) void'(q.pop_front());
      if (e >= 0 && q.size() >= 4) begin
         m_ovf = 1;
         if (clr) m_dcnt = 1;
         else if (m_dcnt < 255) m_dcnt++;
      end else begin
         if (e >= 0) q.push_back(e);
         if (clr) begin m_ovf = 0; m_dcnt = 0; end
      end
   endtask

   task automatic compare_all();
      check("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) check("out_data", out_data, q[0]);
      check("busy", busy, (m_act != 0) || (q.size() > 0));
      check("overflow", overflow, m_ovf);
      check("drop_cnt", drop_cnt, m_dcnt);
   endtask

   task automatic step(input bit sv, input logic [8:0] w, input bit fl,
                       input bit clr, input bit rdy);
      bit pop;
      @(negedge clk);
      compare_all();
      rst_n = 1'b1; sample_valid = sv; word = w; flush = fl; clr_ovf = clr; out_ready = rdy;
      pop = (q.size() > 0) && rdy;
      if (out_valid && out_ready) log_q.push_back(int'(out_data));
      @(posedge clk);
      model_update(sv, w, fl, clr, pop);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; sample_valid = 1'b0; word = '0; flush = 1'b0; clr_ovf = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      model_reset();
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_out_data", out_data, 0);
      check("rst_overflow", overflow, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      log_q.delete();
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(1'b0, 9'h000, 1'b0, 1'b0, rdy);
   endtask

   task automatic check_log(input string name, input int n,
                            input int e0, input int e1, input int e2, input int e3);
      int e[4];
      e = '{e0, e1, e2, e3};
      check({name, "_count"}, log_q.size(), n);
      for (int i = 0; i < n && i < 4; i++)
         if (i < log_q.size()) check({name, "_byte"}, log_q[i], e[i]);
      log_q.delete();
   endtask

   initial begin
      logic [8:0] w, prev;
      bit         stall;
      rst_n = 1'b0; sample_valid = 1'b0; word = '0; flush = 1'b0; clr_ovf = 1'b0; out_ready = 1'b0;
      model_reset();
      do_reset();

`ifdef CTRL_TRACE_RLE_EN
      // three SOUT then flush
      for (int i = 0; i < 3; i++) step(1'b1, 9'h004, 1'b0, 1'b0, 1'b1);
      step(1'b0, 9'h000, 1'b1, 1'b0, 1'b1);
      idle(3, 1'b1);
      check_log("sout_run", 1, 'h02, 0, 0, 0);

      // 17 J: max run then a fresh run
      do_reset();
      for (int i = 0; i < 17; i++) step(1'b1, 9'h100, 1'b0, 1'b0, 1'b1);
      step(1'b0, 9'h000, 1'b1, 1'b0, 1'b1);
      idle(3, 1'b1);
      check_log("j_max_run", 2, 'h4F, 'h40, 0, 0);

      // WM, RM+WR, illegal J+WM
      do_reset();
      step(1'b1, 9'h010, 1'b0, 1'b0, 1'b1);
      step(1'b1, 9'h022, 1'b0, 1'b0, 1'b1);
      step(1'b1, 9'h110, 1'b0, 1'b0, 1'b1);
      step(1'b0, 9'h000, 1'b1, 1'b0, 1'b1);
      idle(3, 1'b1);
      check_log("mixed", 3, 'h20, 'h30, 'h80, 0);

      // flush during a burst is held until the first gap
      do_reset();
      step(1'b1, 9'h002, 1'b1, 1'b0, 1'b1);
      step(1'b1, 9'h002, 1'b0, 1'b0, 1'b1);
      step(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
      idle(3, 1'b1);
      check_log("pend_flush", 1, 'h61, 0, 0, 0);

      // alternating JC / JC+NEQ with a stalled consumer
      do_reset();
      for (int i = 0; i < 6; i++) step(1'b1, (i % 2 == 0) ? 9'h080 : 9'h081, 1'b0, 1'b0, 1'b0);
      step(1'b0, 9'h000, 1'b1, 1'b0, 1'b0);
      idle(1, 1'b0);
      #1;
      check("ovf_set", overflow, 1);
      check("ovf_cnt", drop_cnt, 2);
      idle(6, 1'b1);
      check_log("ovf_held", 4, 'h50, 'h70, 'h50, 'h70);

      // reset with an open run and two queued bytes
      do_reset();
      step(1'b1, 9'h100, 1'b0, 1'b0, 1'b0);
      step(1'b1, 9'h080, 1'b0, 1'b0, 1'b0);
      step(1'b1, 9'h100, 1'b0, 1'b0, 1'b0);
      idle(1, 1'b0);
      do_reset();
      idle(3, 1'b1);
      step(1'b0, 9'h000, 1'b1, 1'b0, 1'b1);
      idle(3, 1'b1);
      check_log("no_stale", 0, 0, 0, 0, 0);
`else
      // two INA+SIN, one byte each
      for (int i = 0; i < 2; i++) step(1'b1, 9'h048, 1'b0, 1'b0, 1'b1);
      idle(3, 1'b1);
      check_log("per_sample", 2, 'h10, 'h10, 0, 0);

      // flush is a no-op
      do_reset();
      step(1'b1, 9'h100, 1'b0, 1'b0, 1'b1);
      step(1'b0, 9'h000, 1'b1, 1'b0, 1'b1);
      idle(3, 1'b1);
      check_log("flush_noop", 1, 'h40, 0, 0, 0);

      // stalled consumer, six samples
      do_reset();
      for (int i = 0; i < 6; i++) step(1'b1, (i % 2 == 0) ? 9'h080 : 9'h081, 1'b0, 1'b0, 1'b0);
      idle(1, 1'b0);
      #1;
      check("ovf_set", overflow, 1);
      check("ovf_cnt", drop_cnt, 2);
      idle(6, 1'b1);
      check_log("ovf_held", 4, 'h50, 'h70, 'h50, 'h70);

      // reset with two queued bytes
      do_reset();
      step(1'b1, 9'h100, 1'b0, 1'b0, 1'b0);
      step(1'b1, 9'h080, 1'b0, 1'b0, 1'b0);
      do_reset();
      idle(4, 1'b1);
      check_log("no_stale", 0, 0, 0, 0, 0);
`endif

      // randomized traffic against the model
      do_reset();
      prev  = 9'h004;
      stall = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if (i % 150 == 0) stall = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) != 0) w = prev;
         else if ($urandom_range(0, 9) < 7) w = legal[$urandom_range(0, 7)];
         else w = 9'($urandom);
         prev = w;
         if ($urandom_range(0, 599) == 0) do_reset();
         else step(1'($urandom_range(0, 1)), w, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 39) == 0,
                   stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0));
      end
      idle(4, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
